// File: rtl/event_sched_pkg.sv
// Shared types and helpers for the timed-event scheduler.
package event_sched_pkg;

    // Index width for a vector of n entries; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int SCHED_NUM_REQ = 4;
    localparam int SCHED_DELAY_W = 8;
    localparam int OWNER_W       = idx_w(SCHED_NUM_REQ);

    // One countdown slot: idle/busy bit, requester that owns it, cycles left.
    typedef struct packed {
        logic                     busy;
        logic [OWNER_W-1:0]       owner;
        logic [SCHED_DELAY_W-1:0] count;
    } slot_t;

endpackage

// File: rtl/event_delay_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts one past the last winner.
module rr_arbiter
    import event_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] grant
);
    localparam int IW = idx_w(N);

    logic [IW-1:0] ptr;
    logic [IW-1:0] ptr_next;

    // Rotating priority search from ptr; the pointer moves only on a grant.
    always_comb begin
        logic found;
        int   idx;
        grant    = '0;
        ptr_next = ptr;
        found    = 1'b0;
        idx      = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
            if (en && !found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
                ptr_next   = (idx == N - 1) ? '0 : IW'(idx + 1);
            end
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) ptr <= '0;
        else     ptr <= ptr_next;
    end

endmodule

// File: rtl/event_delay_scheduler.sv
// Timed-event scheduler: requesters post a delay, a shared pool of countdown
// slots fires a one-cycle pulse back to the owner when the delay runs out.
module event_delay_scheduler
    import event_sched_pkg::*;
#(
    parameter int NUM_REQ = SCHED_NUM_REQ,
    parameter int SLOTS   = 4,
    parameter int DELAY_W = SCHED_DELAY_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DELAY_W-1:0]   req_delay,
    input  logic                         flush,
    output logic [NUM_REQ-1:0]           req_grant,
    output logic [NUM_REQ-1:0]           fire,
    output logic                         coalesced,
    output logic [$clog2(SLOTS+1)-1:0]   pending,
    output logic                         full
);
    localparam int PEND_W  = $clog2(SLOTS + 1);
    localparam int SLOT_IW = idx_w(SLOTS);

    slot_t                slots [SLOTS];
    logic [SLOTS-1:0]     expiring;
    logic [SLOTS-1:0]     free;
    logic                 accept_en;
    logic                 accept;
    logic [SLOT_IW-1:0]   free_idx;
    logic [OWNER_W-1:0]   grant_idx;
    logic [DELAY_W-1:0]   grant_delay;
    logic [PEND_W-1:0]    pending_next;

    // A busy slot at zero expires now; its place is reusable in the same cycle.
    always_comb begin
        expiring = '0;
        free     = '0;
        for (int s = 0; s < SLOTS; s++) begin
            expiring[s] = slots[s].busy && (slots[s].count == '0);
            free[s]     = !slots[s].busy || expiring[s];
        end
    end

    assign full      = ~|free;
    assign accept_en = !full && !flush && !rst;
    assign accept    = |req_grant;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req_valid),
        .en    (accept_en),
        .grant (req_grant)
    );

    // Lowest-index free slot and the index/delay of the granted requester.
    always_comb begin
        free_idx  = '0;
        grant_idx = '0;
        for (int s = SLOTS - 1; s >= 0; s--) begin
            if (free[s]) free_idx = SLOT_IW'(s);
        end
        for (int r = 0; r < NUM_REQ; r++) begin
            if (req_grant[r]) grant_idx = OWNER_W'(r);
        end
        grant_delay = req_delay[grant_idx*DELAY_W +: DELAY_W];
    end

    // Fire decode per owner, coalesce detection, and next occupancy count.
    always_comb begin
        logic [NUM_REQ-1:0] fire_c;
        logic               coal_c;
        int                 exp_cnt;
        fire_c  = '0;
        coal_c  = 1'b0;
        exp_cnt = 0;
        for (int s = 0; s < SLOTS; s++) begin
            if (expiring[s]) begin
                if (fire_c[slots[s].owner]) coal_c = 1'b1;
                fire_c[slots[s].owner] = 1'b1;
                exp_cnt = exp_cnt + 1;
            end
        end
        // Cancelled or reset events never produce a pulse.
        if (flush || rst) begin
            fire_c = '0;
            coal_c = 1'b0;
        end
        fire      = fire_c;
        coalesced = coal_c;
        if (flush) pending_next = '0;
        else       pending_next = PEND_W'(int'(pending) + int'(accept) - exp_cnt);
    end

    // Slot array and occupancy register; only the busy bits need a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SLOTS; s++) slots[s].busy <= 1'b0;
            pending <= '0;
        end else begin
            for (int s = 0; s < SLOTS; s++) begin
                if (flush) begin
                    slots[s].busy <= 1'b0;
                end else if (accept && free_idx == SLOT_IW'(s)) begin
                    slots[s].busy  <= 1'b1;
                    slots[s].owner <= grant_idx;
                    slots[s].count <= grant_delay;
                end else if (expiring[s]) begin
                    slots[s].busy <= 1'b0;
                end else if (slots[s].busy) begin
                    slots[s].count <= slots[s].count - DELAY_W'(1);
                end
            end
            pending <= pending_next;
        end
    end

endmodule

// File: tb/tb_event_delay_scheduler.sv
// Bench for event_delay_scheduler: a reference model tracks pending events by
// absolute due cycle and checks every output each cycle.
module tb_event_delay_scheduler;
    localparam int NR = 4;
    localparam int NS = 4;
    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_delay;
    logic              flush;
    logic [NR-1:0]     req_grant;
    logic [NR-1:0]     fire;
    logic              coalesced;
    logic [2:0]        pending;
    logic              full;

    always #5 clk = ~clk;

    event_delay_scheduler #(.NUM_REQ(NR), .SLOTS(NS), .DELAY_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_delay (req_delay),
        .flush     (flush),
        .req_grant (req_grant),
        .fire      (fire),
        .coalesced (coalesced),
        .pending   (pending),
        .full      (full)
    );

    typedef struct {
        int owner;
        int due;
    } ev_t;

    ev_t  evq[$];
    int   cyc  = 0;
    int   rptr = 0;
    int   passed = 0;
    int   total  = 0;

    // {grant[12:9], fire[8:5], coalesced[4], pending[3:1], full[0]}
    logic [12:0] obs_vec;
    logic [12:0] exp_vec;

    // Drive one cycle of inputs, capture DUT outputs and the model's prediction,
    // then advance the model to the next cycle.
    task automatic cycle(input logic [NR-1:0] v, input logic [NR*DW-1:0] d,
                         input logic fl, input logic r);
        logic [NR-1:0] eg, ef;
        logic          ec, efull;
        int            nexp, g, idx;
        req_valid = v;
        req_delay = d;
        flush     = fl;
        rst       = r;
        @(negedge clk);
        eg = '0; ef = '0; ec = 1'b0; nexp = 0; g = -1;
        foreach (evq[k]) begin
            if (evq[k].due == cyc) begin
                nexp++;
                if (ef[evq[k].owner]) ec = 1'b1;
                ef[evq[k].owner] = 1'b1;
            end
        end
        if (fl || r) begin
            ef = '0;
            ec = 1'b0;
        end
        efull = (evq.size() == NS) && (nexp == 0);
        if (!efull && !fl && !r && (v != '0)) begin
            for (int i = 0; i < NR; i++) begin
                idx = (rptr + i) % NR;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        if (g >= 0) eg[g] = 1'b1;
        exp_vec = {eg, ef, ec, 3'(evq.size()), efull};
        obs_vec = {req_grant, fire, coalesced, pending, full};
        if (r) begin
            evq.delete();
            rptr = 0;
        end else if (fl) begin
            evq.delete();
        end else begin
            for (int k = evq.size() - 1; k >= 0; k--)
                if (evq[k].due == cyc) evq.delete(k);
            if (g >= 0) begin
                evq.push_back('{g, cyc + 1 + int'(d[g*DW +: DW])});
                rptr = (g + 1) % NR;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cycle('0, '0, 1'b0, 1'b1);
        cycle('0, '0, 1'b0, 1'b1);
        cycle('0, '0, 1'b0, 1'b0);
        total++;
        if (obs_vec !== 13'b0) $display("FAIL reset_state: got %b expected %b", obs_vec, 13'b0);
        else passed++;
        total++;
        if (obs_vec !== exp_vec) $display("FAIL reset_model: got %b expected %b", obs_vec, exp_vec);
        else passed++;
    endtask

    task automatic test_single();
        int t0 = -1;
        int fc = -1;
        cycle('0, '0, 1'b0, 1'b1);
        for (int n = 0; n < 12; n++) begin
            cycle((t0 < 0) ? 4'b0100 : 4'b0000, {4{8'd5}}, 1'b0, 1'b0);
            total++;
            if (obs_vec !== exp_vec) $display("FAIL single n=%0d: got %b expected %b", n, obs_vec, exp_vec);
            else passed++;
            if (t0 < 0 && obs_vec[11]) t0 = n;
            if (fc < 0 && obs_vec[7]) fc = n;
        end
        total++;
        if (t0 !== 0 || fc !== 6) $display("FAIL single_latency: got grant %0d fire %0d expected 0 and 6", t0, fc);
        else passed++;
    endtask

    task automatic test_extremes();
        logic [NR*DW-1:0] d;
        int fc = -1;
        cycle('0, '0, 1'b0, 1'b1);
        cycle(4'b0001, '0, 1'b0, 1'b0);
        total++;
        if (obs_vec[12:9] !== 4'b0001) $display("FAIL delay0_grant: got %b expected 0001", obs_vec[12:9]);
        else passed++;
        d = '0;
        d[DW +: DW] = 8'd255;
        cycle(4'b0010, d, 1'b0, 1'b0);
        total++;
        if (obs_vec[8:5] !== 4'b0001 || obs_vec[12:9] !== 4'b0010)
            $display("FAIL delay0_fire: got fire %b grant %b expected 0001 0010", obs_vec[8:5], obs_vec[12:9]);
        else passed++;
        for (int n = 1; n <= 258; n++) begin
            cycle('0, '0, 1'b0, 1'b0);
            total++;
            if (obs_vec !== exp_vec) $display("FAIL delay255 n=%0d: got %b expected %b", n, obs_vec, exp_vec);
            else passed++;
            if (fc < 0 && obs_vec[6]) fc = n;
        end
        total++;
        if (fc !== 256) $display("FAIL delay255_latency: got %0d expected 256", fc);
        else passed++;
    endtask

    task automatic test_round_robin();
        logic [15:0] gseq;
        cycle('0, '0, 1'b0, 1'b1);
        gseq = '0;
        for (int n = 0; n < 26; n++) begin
            cycle(4'b1111, {4{8'd20}}, 1'b0, 1'b0);
            total++;
            if (obs_vec !== exp_vec) $display("FAIL rr n=%0d: got %b expected %b", n, obs_vec, exp_vec);
            else passed++;
            if (n < 4) gseq = {gseq[11:0], obs_vec[12:9]};
            if (n == 4) begin
                total++;
                if (obs_vec[12:9] !== 4'b0000 || obs_vec[0] !== 1'b1)
                    $display("FAIL rr_full: got grant %b full %b expected 0000 1", obs_vec[12:9], obs_vec[0]);
                else passed++;
            end
            if (n == 21) begin
                total++;
                if (obs_vec[12:9] !== 4'b0001) $display("FAIL rr_resume: got %b expected 0001", obs_vec[12:9]);
                else passed++;
            end
        end
        total++;
        if (gseq !== 16'h1248) $display("FAIL rr_order: got %h expected 1248", gseq);
        else passed++;
    endtask

    task automatic test_overlap();
        logic [NR-1:0] vseq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b1000};
        cycle('0, '0, 1'b0, 1'b1);
        for (int n = 0; n < 10; n++) begin
            cycle((n < 5) ? vseq[n] : 4'b0000, (n == 0) ? {4{8'd3}} : {4{8'd20}}, 1'b0, 1'b0);
            total++;
            if (obs_vec !== exp_vec) $display("FAIL overlap n=%0d: got %b expected %b", n, obs_vec, exp_vec);
            else passed++;
            if (n == 4) begin
                total++;
                if ({obs_vec[12:9], obs_vec[8:5], obs_vec[3:0]} !== {4'b1000, 4'b0001, 3'd4, 1'b0})
                    $display("FAIL overlap_reuse: got %b expected %b", {obs_vec[12:9], obs_vec[8:5], obs_vec[3:0]}, {4'b1000, 4'b0001, 3'd4, 1'b0});
                else passed++;
            end
        end
    endtask

    task automatic test_coalesce();
        int pulses = 0;
        cycle('0, '0, 1'b0, 1'b1);
        for (int n = 0; n < 8; n++) begin
            cycle((n < 2) ? 4'b0010 : 4'b0000, (n == 0) ? {4{8'd3}} : {4{8'd2}}, 1'b0, 1'b0);
            total++;
            if (obs_vec !== exp_vec) $display("FAIL coalesce n=%0d: got %b expected %b", n, obs_vec, exp_vec);
            else passed++;
            if (obs_vec[6]) pulses++;
            if (n == 4) begin
                total++;
                if (obs_vec[8:4] !== 5'b00101) $display("FAIL coalesce_pulse: got %b expected 00101", obs_vec[8:4]);
                else passed++;
            end
        end
        total++;
        if (pulses !== 1) $display("FAIL coalesce_count: got %0d expected 1", pulses);
        else passed++;
    endtask

    task automatic test_cancel(input logic use_rst);
        int pulses = 0;
        cycle('0, '0, 1'b0, 1'b1);
        for (int n = 0; n < 20; n++) begin
            cycle((n < 3) ? (4'b0001 << n) : 4'b0000, {4{8'd10}},
                  (!use_rst && n == 9), (use_rst && n == 9));
            total++;
            if (obs_vec !== exp_vec) $display("FAIL cancel%0d n=%0d: got %b expected %b", use_rst, n, obs_vec, exp_vec);
            else passed++;
            if (obs_vec[8:5] != 4'b0000) pulses++;
            if (n == 10) begin
                total++;
                if (obs_vec[3:1] !== 3'd0) $display("FAIL cancel%0d_pending: got %0d expected 0", use_rst, obs_vec[3:1]);
                else passed++;
            end
        end
        total++;
        if (pulses !== 0) $display("FAIL cancel%0d_pulses: got %0d expected 0", use_rst, pulses);
        else passed++;
    endtask

    task automatic test_random();
        logic [NR-1:0]    pv;
        logic [NR*DW-1:0] pd;
        logic             fl, r;
        pv = '0;
        pd = '0;
        cycle('0, '0, 1'b0, 1'b1);
        for (int n = 0; n < 3000; n++) begin
            for (int q = 0; q < NR; q++) begin
                if (!pv[q] && ($urandom_range(0, 2) == 0)) begin
                    pv[q] = 1'b1;
                    pd[q*DW +: DW] = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255))
                                                                  : 8'($urandom_range(0, 23));
                end
            end
            fl = ($urandom_range(0, 63) == 0);
            r  = ($urandom_range(0, 499) == 0);
            cycle(pv, pd, fl, r);
            total++;
            if (obs_vec !== exp_vec) $display("FAIL random n=%0d: got %b expected %b", n, obs_vec, exp_vec);
            else passed++;
            pv = pv & ~obs_vec[12:9];
        end
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = '0;
        req_delay = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_extremes();
        test_round_robin();
        test_overlap();
        test_coalesce();
        test_cancel(1'b0);
        test_cancel(1'b1);
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/event_delay_scheduler.md
# event_delay_scheduler

Synthesizable timed-event scheduler: requesters post "fire me after D cycles" requests, and the block emits a one-cycle event pulse per requester when each delay expires. It replaces the behavioural `-> e; #D; @(e)` pattern in synthesizable top-levels. It sits between requesting FSMs and the logic that waits on their events. It shares a small pool of countdown slots among requesters through a round-robin arbiter.

## Interface
- NUM_REQ, 4: number of requesters (≥2).
- SLOTS, 4: number of concurrent pending events (≥1).
- DELAY_W, 8: width of the requested delay.
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester schedule request; held until granted.
- req_delay  in  NUM_REQ×DELAY_W  packed delay per requester.
- flush  in  1  synchronous cancel of all pending events.
- req_grant  out  NUM_REQ  one-hot accept in this cycle (zero if none).
- fire  out  NUM_REQ  one-cycle event pulse per requester.
- coalesced  out  1  ≥2 slots of the same requester expired this cycle.
- pending  out  $clog2(SLOTS+1)  number of occupied slots.
- full  out  1  all slots occupied and none expiring this cycle.

## Operation
- Each slot holds busy, owner (requester index), and count (DELAY_W bits).
- Accept: if `!full && !flush && |req_valid`, the round-robin arbiter picks one requester and asserts its req_grant bit. The lowest-index free slot is loaded with busy=1, owner, and count=req_delay. A slot that is expiring this cycle counts as free.
- Round-robin: the pointer starts at 0. After a grant to index g, the next search starts at g+1 mod NUM_REQ. The pointer is unchanged when there is no grant.
- Countdown: each busy slot with count≠0 decrements by 1 per cycle. A busy slot with count==0 expires: fire[owner]=1 in that cycle and the slot clears at the edge.
- fire is the OR over expiring slots per owner. coalesced=1 when any owner has ≥2 expiring slots.
- flush clears all slots at the edge and blocks acceptance in that cycle. fire and coalesced are forced to 0 in the flush cycle.
- pending is the registered count of busy slots. It is updated by both accept and expire.
- A requester may hold multiple pending slots.
- Delays do not wrap: max delay is 2^DELAY_W−1.
- No FSM beyond the per-slot idle/busy bit.

## Timing
- Reset: all slots idle, arbiter pointer=0, req_grant=0, fire=0, coalesced=0, pending=0, full=0.
- Reset asserted mid-operation discards all pending events with no fire pulses.
- Request granted in cycle T with delay D ⇒ fire[owner] asserted in exactly cycle T+1+D.
  - D=0 fires in cycle T+1.
- req_grant is combinational from req_valid, slot state and pointer. Requester drops or updates req_valid in the cycle after its grant.
- fire and coalesced are combinational from registered slot state: a single decode, no extra pipeline.
- full=1 exactly when SLOTS slots are busy and none is expiring.
  - An accept in the same cycle as an expiry reuses the freed slot. pending stays unchanged.
- Simultaneous flush and rst: rst wins. The result is identical.

## Structure
- Package `event_sched_pkg` holds:
  - `slot_t` struct (busy, owner, count), parameterized via localparams;
  - the helper function for the owner index width.
- Sub-module `rr_arbiter` (parameter N): inputs req vector and enable; outputs one-hot grant; internal rotating pointer.
- The top holds the slot array, free-slot priority encoder, fire OR-reduction, and pending counter.

## Test plan
- Reset then single request: req 2 with delay 5 granted at cycle 10 ⇒ fire[2] only in cycle 16, pending 1→0 at cycle 17.
- Delay 0 and max: req 0 delay 0 at T ⇒ fire[0] at T+1. Req 1 delay 255 ⇒ fire[1] at T+256, no early wrap.
- Round-robin fairness: all 4 requesting continuously with delay 20 ⇒ grants 0,1,2,3 in consecutive cycles, full=1 after the 4th, no grant while full. Grants resume after the first expiry, starting at index 0.
- Expiry/accept overlap: 4 slots full, slot expiring in cycle T while req 3 requests ⇒ grant in T, pending stays 4, full=0 in T.
- Coalesce: req 1 twice with delays 3 then 2 on consecutive cycles ⇒ single fire[1] pulse with coalesced=1 in the same cycle.
- Flush/reset mid-flight: 3 pending events, flush (or rst) 2 cycles before the first expiry ⇒ pending=0 next cycle, no fire pulses ever for them.
